// File: rtl/motor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | motor_pkg : shared types, constants and ramp arithmetic helpers   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package motor_pkg;

  localparam int SPEED_W = 9;

  typedef logic [SPEED_W-1:0] speed_t;
  typedef logic [1:0]         drive_mode_t;

  localparam drive_mode_t MODE_OFF   = 2'd0;
  localparam drive_mode_t MODE_DRIVE = 2'd1;
  localparam drive_mode_t MODE_BRAKE = 2'd2;
  localparam drive_mode_t MODE_COAST = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DECEL = 2'd1,
    ST_DWELL = 2'd2
  } ramp_state_e;

  // Move cur one step toward tgt; snap to tgt when within one step.
  function automatic speed_t ramp_toward(input speed_t cur, input speed_t tgt, input speed_t step);
    logic signed [SPEED_W:0] diff;
    logic signed [SPEED_W:0] lim;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    lim  = $signed({1'b0, step});
    if ((diff <= lim) && (diff >= -lim)) begin
      return tgt;
    end else if (diff > 0) begin
      return cur + step;
    end else begin
      return cur - step;
    end
  endfunction

  function automatic speed_t sat_dec(input speed_t cur, input speed_t step);
    return (cur > step) ? (cur - step) : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_cmd_ramp_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | motor_cmd_ramp_if : command side and motor-driver side of the ramp |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface motor_cmd_ramp_if;
  import motor_pkg::*;

  logic        cmd_strobe;
  speed_t      cmd_speed;
  logic        cmd_dir;
  drive_mode_t cmd_mode;
  logic        timeout;

  speed_t      motor_speed;
  logic        motor_dir;
  drive_mode_t drive_mode;
  logic        ramping;

  modport master (
    output cmd_strobe, cmd_speed, cmd_dir, cmd_mode, timeout,
    input  motor_speed, motor_dir, drive_mode, ramping
  );

  modport slave (
    input  cmd_strobe, cmd_speed, cmd_dir, cmd_mode, timeout,
    output motor_speed, motor_dir, drive_mode, ramping
  );

endinterface
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_divider : free-running prescaler, one-cycle tick every DIV    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tick_divider #(
  parameter int DIV = 1024
) (
  input  logic sysclk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(DIV - 2);

  logic [CNT_W-1:0] cnt;

  // tick is registered so it is high exactly while cnt == DIV-1.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= (cnt == PRE);
    end
  end

endmodule
`default_nettype wire

// File: rtl/motor_cmd_ramp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | motor_cmd_ramp : slew-limits speed commands, reverses via a dwell  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module motor_cmd_ramp
  import motor_pkg::*;
#(
  parameter int STEP        = 4,
  parameter int TICK_DIV    = 1024,
  parameter int DWELL_TICKS = 8
) (
  input  logic             sysclk,
  input  logic             reset,
  motor_cmd_ramp_if.slave  bus
);

  localparam speed_t STEP_V = SPEED_W'(STEP);
  localparam int DW_W = $clog2(DWELL_TICKS + 1);
  localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_TICKS);
  localparam logic [DW_W-1:0] DWELL_ONE  = DW_W'(1);

  logic        tick;
  speed_t      motor_speed;
  logic        motor_dir;
  drive_mode_t drive_mode;
  logic        ramping;
  speed_t      tgt_speed;
  logic        tgt_dir;
  drive_mode_t tgt_mode;
  ramp_state_e state;
  logic [DW_W-1:0] dwell_cnt;
  speed_t      dec_speed;

  tick_divider #(.DIV(TICK_DIV)) u_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .tick   (tick)
  );

  assign dec_speed = sat_dec(motor_speed, STEP_V);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      motor_speed <= '0;
      motor_dir   <= 1'b0;
      drive_mode  <= MODE_OFF;
      ramping     <= 1'b0;
      tgt_speed   <= '0;
      tgt_dir     <= 1'b0;
      tgt_mode    <= MODE_OFF;
      state       <= ST_RUN;
      dwell_cnt   <= '0;
    end else begin
      ramping <= (state != ST_RUN) || (motor_speed != tgt_speed) || (motor_dir != tgt_dir);

      if (bus.timeout) begin
        // Watchdog wins over any strobe in the same cycle; the command is dropped.
        motor_speed <= '0;
        drive_mode  <= MODE_OFF;
        tgt_speed   <= '0;
        tgt_mode    <= MODE_OFF;
        state       <= ST_RUN;
        dwell_cnt   <= '0;
      end else if (bus.cmd_strobe && (bus.cmd_mode == MODE_OFF)) begin
        motor_speed <= '0;
        drive_mode  <= MODE_OFF;
        tgt_speed   <= '0;
        tgt_dir     <= bus.cmd_dir;
        tgt_mode    <= MODE_OFF;
        state       <= ST_RUN;
        dwell_cnt   <= '0;
      end else if (!bus.cmd_strobe && (tgt_mode == MODE_OFF)) begin
        motor_speed <= '0;
        tgt_speed   <= '0;
        state       <= ST_RUN;
        dwell_cnt   <= '0;
      end else begin
        if (bus.cmd_strobe) begin
          tgt_speed  <= bus.cmd_speed;
          tgt_dir    <= bus.cmd_dir;
          tgt_mode   <= bus.cmd_mode;
          drive_mode <= bus.cmd_mode;
        end

        // Motion follows the targets registered before this edge, so a new
        // command takes effect on the first tick after its capture.
        unique case (state)
          ST_RUN: begin
            if (tgt_dir != motor_dir) begin
              if (motor_speed == '0) begin
                motor_dir <= tgt_dir;
              end else if (tick) begin
                motor_speed <= dec_speed;
                if (dec_speed == '0) begin
                  state     <= ST_DWELL;
                  dwell_cnt <= DWELL_LOAD;
                end else begin
                  state <= ST_DECEL;
                end
              end else begin
                state <= ST_DECEL;
              end
            end else if (tick) begin
              motor_speed <= ramp_toward(motor_speed, tgt_speed, STEP_V);
            end
          end

          ST_DECEL: begin
            if (tgt_dir == motor_dir) begin
              state <= ST_RUN;
            end else if (tick) begin
              motor_speed <= dec_speed;
              if (dec_speed == '0) begin
                state     <= ST_DWELL;
                dwell_cnt <= DWELL_LOAD;
              end
            end else if (motor_speed == '0) begin
              state     <= ST_DWELL;
              dwell_cnt <= DWELL_LOAD;
            end
          end

          ST_DWELL: begin
            motor_speed <= '0;
            if (tgt_dir == motor_dir) begin
              state     <= ST_RUN;
              dwell_cnt <= '0;
            end else if (tick) begin
              if (dwell_cnt <= DWELL_ONE) begin
                dwell_cnt <= '0;
                motor_dir <= tgt_dir;
                state     <= ST_RUN;
              end else begin
                dwell_cnt <= dwell_cnt - 1'b1;
              end
            end
          end

          default: begin
            state <= ST_RUN;
          end
        endcase
      end
    end
  end

  assign bus.motor_speed = motor_speed;
  assign bus.motor_dir   = motor_dir;
  assign bus.drive_mode  = drive_mode;
  assign bus.ramping     = ramping;

endmodule
`default_nettype wire
